// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: sticky pending register of request lines, one binary
// index per valid/ready transfer, fixed-priority or round-robin selection.
module encoder_8x3_seq #(
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic             ready,
    output logic [2:0]       code,
    output logic             valid,
    output logic [7:0]       pending,
    output logic             busy,
    output logic [CNT_W-1:0] merge_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [2:0]       last, last_next;
    logic [2:0]       code_next;
    logic [7:0]       pending_next;
    logic [7:0]       clr_mask;
    logic [CNT_W-1:0] merge_cnt_next;
    logic [2:0]       sel;
    logic [2:0]       base;
    logic [2:0]       idx;
    logic             found;
    logic             load;
    logic             merge_hit;

    assign valid = (state == HOLD);

    // Scan starts at index 0 for fixed priority, or one past the last grant for round robin.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        base  = (RR_MODE != 0) ? 3'(last + 3'd1) : 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(base + 3'(i));
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next     = state;
        code_next      = code;
        last_next      = last;
        merge_cnt_next = merge_cnt;
        load           = 1'b0;
        clr_mask       = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (found) load = 1'b1;
                    else       state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            code_next = sel;
            last_next = sel;
            clr_mask  = 8'(1) << sel;
        end

        // A request on the bit being cleared re-sets it, so the source is served again.
        pending_next = (pending & ~clr_mask) | req;
        merge_hit    = |(req & pending & ~clr_mask);
        if (merge_hit && !(&merge_cnt))
            merge_cnt_next = merge_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            code      <= '0;
            last      <= 3'd7;
            merge_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            code      <= code_next;
            last      <= last_next;
            merge_cnt <= merge_cnt_next;
            busy      <= (|pending_next) || (state_next == HOLD);
        end
    end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Self-checking bench: fixed-priority and round-robin instances driven with the same
// stimulus, each compared every cycle against a transaction-level reference model.
module tb_encoder_8x3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ready;

    logic [2:0] code0, code1;
    logic       valid0, valid1;
    logic [7:0] pending0, pending1;
    logic       busy0, busy1;
    logic [7:0] merge_cnt0, merge_cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: index 0 = fixed priority, index 1 = round robin.
    int m_pend [2];
    int m_code [2];
    int m_valid[2];
    int m_last [2];
    int m_mc   [2];
    int m_busy [2];

    always #5 clk = ~clk;

    encoder_8x3_seq #(.RR_MODE(0), .CNT_W(8)) u_fp (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code0), .valid(valid0), .pending(pending0), .busy(busy0), .merge_cnt(merge_cnt0)
    );

    encoder_8x3_seq #(.RR_MODE(1), .CNT_W(8)) u_rr (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code1), .valid(valid1), .pending(pending1), .busy(busy1), .merge_cnt(merge_cnt1)
    );

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      tag, observed, observed, expected, expected, $time);
    endtask

    // One edge of the reference: pick a request by policy, hand it over, merge new requests.
    task automatic model_step(input int m, input int r, input int rd, input int rs);
        int start, pick, clr;
        if (rs != 0) begin
            m_pend[m] = 0; m_code[m] = 0; m_valid[m] = 0;
            m_last[m] = 7; m_mc[m] = 0;   m_busy[m] = 0;
            return;
        end
        pick  = -1;
        clr   = 0;
        start = (m == 1) ? (m_last[m] + 1) % 8 : 0;
        if (m_pend[m] != 0 && (m_valid[m] == 0 || rd != 0)) begin
            for (int k = 0; k < 8; k++)
                if (pick < 0 && ((m_pend[m] >> ((start + k) % 8)) & 1) != 0)
                    pick = (start + k) % 8;
            clr = 1 << pick;
        end
        if ((r & m_pend[m] & ~clr) != 0 && m_mc[m] < 255) m_mc[m]++;
        if (pick >= 0) begin
            m_code[m]  = pick;
            m_valid[m] = 1;
            m_last[m]  = pick;
        end else if (m_valid[m] != 0 && rd != 0) begin
            m_valid[m] = 0;
        end
        m_pend[m] = ((m_pend[m] & ~clr) | r) & 8'hFF;
        m_busy[m] = (m_pend[m] != 0 || m_valid[m] != 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("fp_code",    code0,      m_code[0]);
        check("fp_valid",   valid0,     m_valid[0]);
        check("fp_pending", pending0,   m_pend[0]);
        check("fp_busy",    busy0,      m_busy[0]);
        check("fp_merge",   merge_cnt0, m_mc[0]);
        check("rr_code",    code1,      m_code[1]);
        check("rr_valid",   valid1,     m_valid[1]);
        check("rr_pending", pending1,   m_pend[1]);
        check("rr_busy",    busy1,      m_busy[1]);
        check("rr_merge",   merge_cnt1, m_mc[1]);
    endtask

    // Drive one cycle of inputs, step the model on the edge, compare just after it.
    task automatic cycle(input logic [7:0] r, input logic rd, input logic rs);
        req   = r;
        ready = rd;
        rst   = rs;
        @(posedge clk);
        model_step(0, int'(r), int'(rd), int'(rs));
        model_step(1, int'(r), int'(rd), int'(rs));
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] r;
        logic       rd, rs;

        req = '0; ready = 1'b0; rst = 1'b1;
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        check("reset_last_wrap_rr_code", code1, 0);

        // Fixed priority burst: codes 2, 5, 7 back to back.
        cycle(8'hA4, 1'b1, 1'b0);
        check("burst_pending", pending0, 8'hA4);
        cycle(8'h00, 1'b1, 1'b0);
        check("burst_code_a", code0, 2);
        cycle(8'h00, 1'b1, 1'b0);
        check("burst_code_b", code0, 5);
        cycle(8'h00, 1'b1, 1'b0);
        check("burst_code_c", code0, 7);
        check("burst_valid_c", valid0, 1);
        cycle(8'h00, 1'b1, 1'b0);
        check("burst_valid_end", valid0, 0);
        check("burst_busy_end", busy0, 0);

        // Hold with ready low, then one ready pulse.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h01, 1'b0, 1'b0);
        cycle(8'h80, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        check("hold_code", code0, 0);
        check("hold_valid", valid0, 1);
        check("hold_pending", pending0, 8'h80);
        cycle(8'h00, 1'b1, 1'b0);
        check("hold_next_code", code0, 7);
        check("hold_merge", merge_cnt0, 0);

        // Set wins over clear on the load edge.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h10, 1'b0, 1'b0);
        check("setwin_pre_pending", pending0, 8'h18);
        cycle(8'h10, 1'b1, 1'b0);
        check("setwin_code", code0, 3);
        check("setwin_pending", pending0, 8'h10);
        check("setwin_merge", merge_cnt0, 1);

        // Reset in the middle of a transfer.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'hF0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b1);
        check("rst_pending", pending0, 0);
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
        cycle(8'h02, 1'b0, 1'b0);
        check("rst_after_valid_early", valid0, 0);
        cycle(8'h00, 1'b0, 1'b0);
        check("rst_after_code", code0, 1);
        check("rst_after_valid", valid0, 1);

        // Idle: no requests, ready toggling.
        cycle(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(8'h00, 1'(i & 1), 1'b0);
            check("idle_valid", valid1, 0);
        end

        // Round robin with all lines held: cyclic codes and counter saturation.
        cycle(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            if (i >= 1) check("rr_cyclic", code1, (i - 1) % 8);
        end
        check("rr_saturate", merge_cnt1, 255);

        // Randomized traffic with sparse requests and occasional resets.
        for (int i = 0; i < 800; i++) begin
            r  = 8'($urandom & $urandom & $urandom);
            rd = 1'($urandom_range(0, 3) != 0);
            rs = 1'($urandom_range(0, 99) == 0);
            cycle(r, rd, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
